// File: rtl/spiker_result_fifo.sv
// ---------------------------------------------------------------------------
// spiker_result_fifo
//
// Buffers spike frames from the SNN core and hands them to the adapter
// register file. Incoming frames pass a run-time decimator (keeps 1 of every
// decim_i+1 accepted frames). Kept frames go into a DEPTH-entry FIFO. The
// head frame is presented as N_REG words of WIDTH bits.
//
// When the FIFO is full it either back-pressures (mode_i = 0) or overwrites
// the oldest entry (mode_i = 1).
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clr_i             synchronous flush of FIFO, decimator, overflow, frame_cnt
//   mode_i            0 = back-pressure when full, 1 = overwrite oldest
//   decim_i           keep period minus 1 (0 = keep every frame)
//   in_valid_i/in_ready_o/in_data_i   spike frame input handshake
//   pop_i             host consumed the head frame
//   out_valid_o       FIFO non-empty
//   out_words_o       head frame, word i at [(i+1)*WIDTH-1 -: WIDTH]
//   level_o           frames stored
//   sample_o          one-cycle pulse per frame written
//   overflow_o        sticky, set when a stored frame was overwritten
//   frame_cnt_o       frames written since reset/clr, wraps at 2^16
// ---------------------------------------------------------------------------
module spiker_result_fifo #(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 24,
    parameter int DATA_WIDTH = 800,
    parameter int DEPTH      = 4,
    parameter int DEC_W      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         mode_i,
    input  logic [DEC_W-1:0]             decim_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_WIDTH-1:0]        in_data_i,
    input  logic                         pop_i,
    output logic                         out_valid_o,
    output logic [N_REG*WIDTH-1:0]       out_words_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         sample_o,
    output logic                         overflow_o,
    output logic [15:0]                  frame_cnt_o
);

    localparam int FW = N_REG * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Storage and pointers. Pointers carry one extra MSB so that
    // full (MSBs differ, index equal) and empty (equal) are distinct.
    logic [DEPTH-1:0][FW-1:0]     mem;
    logic [AW:0]                  wr_ptr, rd_ptr;
    logic [DEC_W-1:0]             dec_cnt;
    logic                         overflow;
    logic                         sample;
    logic [15:0]                  frame_cnt;

    logic [N_REG-1:0][WIDTH-1:0]  wr_frame;
    logic [AW:0]                  count;
    logic                         full, empty;
    logic                         hs, keep, wr_en, pop_ok, ovw, rd_adv;

    // Unpack the kept part of the spike frame into result words.
    for (genvar i = 0; i < N_REG; i++) begin : g_word
        assign wr_frame[i] = in_data_i[(i+1)*WIDTH-1 -: WIDTH];
    end

    // Bits above N_REG*WIDTH are intentionally dropped.
    if (DATA_WIDTH > FW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^in_data_i[DATA_WIDTH-1:FW];
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Depends only on registered state and mode_i, never on pop_i.
    assign in_ready_o = mode_i | ~full;

    // Every handshake ticks the decimator. The >= test means a lowered
    // decim_i releases the counter on the next handshake instead of
    // waiting for a wrap.
    assign hs     = in_valid_i & in_ready_o;
    assign keep   = hs & (dec_cnt >= decim_i);
    assign wr_en  = keep & ~clr_i;
    assign pop_ok = pop_i & ~empty & ~clr_i;

    // A write into a full FIFO is only possible in overwrite mode. Without
    // a pop, the oldest entry is discarded by advancing the read pointer.
    assign ovw    = wr_en & full & ~pop_ok;
    assign rd_adv = pop_ok | ovw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr_i) begin
            // Flush by catching the reader up. Storage keeps its contents.
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_frame;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_cnt <= '0;
        end else if (clr_i) begin
            dec_cnt <= '0;
        end else if (hs) begin
            dec_cnt <= keep ? '0 : dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow  <= 1'b0;
            sample    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            sample <= wr_en;
            if (clr_i) begin
                overflow  <= 1'b0;
                frame_cnt <= '0;
            end else begin
                if (ovw)   overflow  <= 1'b1;
                if (wr_en) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign out_valid_o = ~empty;
    assign out_words_o = mem[rd_ptr[AW-1:0]];
    assign level_o     = LW'(count);
    assign sample_o    = sample;
    assign overflow_o  = overflow;
    assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_spiker_result_fifo.sv
module tb_spiker_result_fifo;

    localparam int WIDTH = 32;
    localparam int N_REG = 24;
    localparam int DW    = 800;
    localparam int DEPTH = 4;
    localparam int DEC_W = 4;
    localparam int FW    = N_REG * WIDTH;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             mode;
    logic [DEC_W-1:0] decim;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             pop;
    logic             out_valid;
    logic [FW-1:0]    out_words;
    logic [LW-1:0]    level;
    logic             sample;
    logic             overflow;
    logic [15:0]      frame_cnt;

    spiker_result_fifo #(
        .WIDTH(WIDTH), .N_REG(N_REG), .DATA_WIDTH(DW), .DEPTH(DEPTH), .DEC_W(DEC_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .mode_i(mode), .decim_i(decim),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .pop_i(pop), .out_valid_o(out_valid), .out_words_o(out_words),
        .level_o(level), .sample_o(sample), .overflow_o(overflow),
        .frame_cnt_o(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int samples  = 0;
    int s0;
    logic [FW-1:0] exp_q[$];

    // Frame k: 32-bit word i = {k[15:0], i[15:0]}; 25 words fill 800 bits.
    function automatic logic [DW-1:0] mk(input int k);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {k[15:0], 16'(i)};
        return d;
    endfunction

    // Stored head: only the low N_REG words survive.
    function automatic logic [FW-1:0] ex(input int k);
        logic [DW-1:0] d;
        d = mk(k);
        return d[FW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic chkw(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Scoreboard monitor: whenever the host pops a valid head, it must be
    // the oldest expected frame.
    task automatic monitor();
        logic [FW-1:0] e;
        forever begin
            @(negedge clk);
            if (sample) samples++;
            if (rst_n && pop && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chkw("sb_head", out_words, e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic send(input int k);
        in_valid = 1'b1;
        in_data  = mk(k);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic popc();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        mode     = 1'b0;
        decim    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        pop      = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level",     64'(level),     64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chkw("rst_words",    out_words,      '0);
        #11 rst_n = 1'b1;
        fork monitor(); join_none
        tick();

        // 1: keep every frame, two pushes then two pops
        s0 = samples;
        send(1); exp_q.push_back(ex(1));
        at_neg();
        chkw("t1_head_A", out_words, ex(1));
        chk("t1_level1", 64'(level), 64'd1);
        chk("t1_sample", 64'(sample), 64'd1);
        tick();
        send(2); exp_q.push_back(ex(2));
        at_neg();
        chk("t1_level2", 64'(level), 64'd2);
        chkw("t1_head_still_A", out_words, ex(1));
        tick();
        chk("t1_samples", 64'(samples - s0), 64'd2);
        popc();
        at_neg();
        chkw("t1_head_B", out_words, ex(2));
        tick();
        popc();
        at_neg();
        chk("t1_empty", 64'(out_valid), 64'd0);
        tick();

        // 2: decimate by 15 over 30 frames -> frames 15 and 30 kept
        decim = 4'd14;
        clr_pulse();
        s0 = samples;
        for (int k = 1; k <= 30; k++) send(100 + k);
        exp_q.push_back(ex(115));
        exp_q.push_back(ex(130));
        at_neg();
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("t2_level", 64'(level), 64'd2);
        tick();
        chk("t2_samples", 64'(samples - s0), 64'd2);
        popc();
        popc();
        decim = '0;

        // 3: back-pressure stall when full, released by one pop
        clr_pulse();
        for (int k = 201; k <= 204; k++) begin send(k); exp_q.push_back(ex(k)); end
        at_neg();
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        chk("t3_full_level", 64'(level), 64'd4);
        tick();
        in_valid = 1'b1;
        in_data  = mk(205);
        tick();
        tick();
        at_neg();
        chk("t3_stall_level", 64'(level), 64'd4);
        chk("t3_stall_ready", 64'(in_ready), 64'd0);
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        at_neg();
        chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
        chk("t3_level3", 64'(level), 64'd3);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(ex(205));
        at_neg();
        chk("t3_level_refill", 64'(level), 64'd4);
        tick();
        for (int k = 0; k < 4; k++) popc();

        // 4: overwrite-oldest
        mode = 1'b1;
        clr_pulse();
        for (int k = 301; k <= 304; k++) begin send(k); exp_q.push_back(ex(k)); end
        send(305);
        void'(exp_q.pop_front());
        exp_q.push_back(ex(305));
        at_neg();
        chkw("t4_head_F2", out_words, ex(302));
        chk("t4_level", 64'(level), 64'd4);
        chk("t4_overflow", 64'(overflow), 64'd1);
        tick();
        clr_pulse();
        at_neg();
        chk("t4_clr_overflow", 64'(overflow), 64'd0);
        tick();
        for (int k = 311; k <= 314; k++) begin send(k); exp_q.push_back(ex(k)); end
        in_valid = 1'b1;
        in_data  = mk(315);
        pop      = 1'b1;
        tick();
        in_valid = 1'b0;
        pop      = 1'b0;
        exp_q.push_back(ex(315));
        at_neg();
        chk("t4_pp_overflow", 64'(overflow), 64'd0);
        chk("t4_pp_level", 64'(level), 64'd4);
        chkw("t4_pp_head", out_words, ex(312));
        tick();
        for (int k = 0; k < 4; k++) popc();
        mode = 1'b0;

        // 5: clr beats a concurrent write and pop
        clr_pulse();
        for (int k = 401; k <= 403; k++) begin send(k); exp_q.push_back(ex(k)); end
        at_neg();
        chk("t5_level3", 64'(level), 64'd3);
        tick();
        s0 = samples;
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = mk(409);
        pop      = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        pop      = 1'b0;
        exp_q.delete();
        at_neg();
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t5_sample", 64'(sample), 64'd0);
        tick();
        chk("t5_no_samples", 64'(samples - s0), 64'd0);

        // 6: async reset mid-burst
        send(501); exp_q.push_back(ex(501));
        send(502); exp_q.push_back(ex(502));
        in_valid = 1'b1;
        in_data  = mk(503);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t6_sample", 64'(sample), 64'd0);
        chkw("t6_words", out_words, '0);
        in_valid = 1'b0;
        exp_q.delete();
        at_neg();
        rst_n = 1'b1;
        tick();
        send(504); exp_q.push_back(ex(504));
        at_neg();
        chkw("t6_head", out_words, ex(504));
        chk("t6_level1", 64'(level), 64'd1);
        chk("t6_frame_cnt1", 64'(frame_cnt), 64'd1);
        tick();
        popc();
        at_neg();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("final_level", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
